// File: rtl/cnn_mac_pkg.sv
// -----------------------------------------------------------------------------
// cnn_mac_pkg
// Shared defaults and helpers for the CNN multiply-accumulate pipeline.
//   - Default operand / accumulator / result widths, pipeline depth and
//     fixed-point shift used by cnn_mul_acc_pipe and cnn_mac_mul_pipe.
//   - Saturation helpers that clip a sign-extended 64-bit value to a signed
//     range of a given width and report whether clipping happened.
// Optional feature macro (consumed by cnn_mul_acc_pipe): CNN_MAC_SAT_EN.
// -----------------------------------------------------------------------------
package cnn_mac_pkg;

    localparam int DIN0_W_DEF     = 8;
    localparam int DIN1_W_DEF     = 14;
    localparam int ACC_W_DEF      = 32;
    localparam int DOUT_W_DEF     = 16;
    localparam int NUM_STAGE_DEF  = 3;
    localparam int FRAC_SHIFT_DEF = 0;

    // Largest value representable as a signed number of width w.
    function automatic logic signed [63:0] sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable as a signed number of width w.
    function automatic logic signed [63:0] sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // True when v does not fit in a signed w-bit result.
    function automatic logic sat_out_of_range(input logic signed [63:0] v, input int w);
        return (v > sat_hi(w)) || (v < sat_lo(w));
    endfunction

    // Clip v into the signed w-bit range; the caller truncates to w bits.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
        logic signed [63:0] r;
        if (v > sat_hi(w)) begin
            r = sat_hi(w);
        end else if (v < sat_lo(w)) begin
            r = sat_lo(w);
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// -----------------------------------------------------------------------------
// cnn_mac_mul_pipe
// Signed full-width multiplier followed by NUM_STAGE registers carrying the
// product together with the window flags and a valid bit. All stages advance
// together under i_en; with i_en low the whole pipe holds.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_en                shift enable (common to every stage)
//   i_a, i_b            signed operands
//   i_first, i_last     window delimiters travelling with the product
//   i_valid             beat present at the pipe input
//   o_p                 signed product at pipe exit (A_W+B_W bits)
//   o_first, o_last     flags at pipe exit
//   o_valid             valid bit at pipe exit
// -----------------------------------------------------------------------------
module cnn_mac_mul_pipe
    import cnn_mac_pkg::*;
#(
    parameter int A_W       = DIN0_W_DEF,
    parameter int B_W       = DIN1_W_DEF,
    parameter int NUM_STAGE = NUM_STAGE_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_en,
    input  logic signed [A_W-1:0]       i_a,
    input  logic signed [B_W-1:0]       i_b,
    input  logic                        i_first,
    input  logic                        i_last,
    input  logic                        i_valid,
    output logic signed [A_W+B_W-1:0]   o_p,
    output logic                        o_first,
    output logic                        o_last,
    output logic                        o_valid
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] w_prod;
    logic signed [P_W-1:0] r_p     [NUM_STAGE];
    logic                  r_first [NUM_STAGE];
    logic                  r_last  [NUM_STAGE];
    logic                  r_valid [NUM_STAGE];

    // Both operands are sign-extended to the product width before multiplying
    // so the full product is kept without truncation.
    assign w_prod = P_W'(i_a) * P_W'(i_b);

    // Product / flag / valid shift register, frozen when i_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGE; s++) begin
                r_p[s]     <= '0;
                r_first[s] <= 1'b0;
                r_last[s]  <= 1'b0;
                r_valid[s] <= 1'b0;
            end
        end else if (i_en) begin
            r_p[0]     <= w_prod;
            r_first[0] <= i_first;
            r_last[0]  <= i_last;
            r_valid[0] <= i_valid;
            for (int s = 1; s < NUM_STAGE; s++) begin
                r_p[s]     <= r_p[s-1];
                r_first[s] <= r_first[s-1];
                r_last[s]  <= r_last[s-1];
                r_valid[s] <= r_valid[s-1];
            end
        end
    end

    assign o_p     = r_p[NUM_STAGE-1];
    assign o_first = r_first[NUM_STAGE-1];
    assign o_last  = r_last[NUM_STAGE-1];
    assign o_valid = r_valid[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mul_acc_pipe.sv
// -----------------------------------------------------------------------------
// cnn_mul_acc_pipe
// Streaming signed multiply-accumulate over windows delimited by in_first /
// in_last. Each accepted beat is multiplied in a NUM_STAGE-deep pipe; at pipe
// exit the product opens (in_first) or extends the running sum. The beat that
// closes a window loads dout with the sum arithmetically shifted right by
// FRAC_SHIFT and reduced to dout_WIDTH bits.
// Optional feature macro: CNN_MAC_SAT_EN
//   defined   -> reduce by saturating, sat_flag marks clipped results
//   undefined -> reduce by keeping the low dout_WIDTH bits, sat_flag = 0
// Ports:
//   ap_clk, ap_rst_n     clock, asynchronous active-low reset
//   din0, din1           signed operands
//   in_first, in_last    window open / close flags
//   in_valid, in_ready   input handshake (in_ready is combinational)
//   dout, out_valid      registered window result and its valid
//   out_ready            consumer ready
//   sat_flag             result was clipped (qualified by out_valid)
// -----------------------------------------------------------------------------
module cnn_mul_acc_pipe
    import cnn_mac_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W_DEF,
    parameter int din1_WIDTH = DIN1_W_DEF,
    parameter int acc_WIDTH  = ACC_W_DEF,
    parameter int dout_WIDTH = DOUT_W_DEF,
    parameter int NUM_STAGE  = NUM_STAGE_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sat_flag
);

    localparam int P_W = din0_WIDTH + din1_WIDTH;

    logic                         w_in_ready;
    logic                         w_accept;
    logic signed [P_W-1:0]        w_exit_p;
    logic                         w_exit_first;
    logic                         w_exit_last;
    logic                         w_exit_valid;
    logic signed [acc_WIDTH-1:0]  w_p_ext;
    logic signed [acc_WIDTH-1:0]  w_sum;
    logic signed [acc_WIDTH-1:0]  w_shift;
    logic signed [dout_WIDTH-1:0] w_dout;
    logic                         w_clip;

    logic signed [acc_WIDTH-1:0]  r_acc;
    logic signed [dout_WIDTH-1:0] r_dout;
    logic                         r_out_valid;
    logic                         r_sat;

    // A held result the consumer has not taken stalls the whole datapath.
    assign w_in_ready = !(r_out_valid && !out_ready);
    assign w_accept   = in_valid && w_in_ready;

    cnn_mac_mul_pipe #(
        .A_W       (din0_WIDTH),
        .B_W       (din1_WIDTH),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul_pipe (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_en    (w_in_ready),
        .i_a     (din0),
        .i_b     (din1),
        .i_first (in_first),
        .i_last  (in_last),
        .i_valid (w_accept),
        .o_p     (w_exit_p),
        .o_first (w_exit_first),
        .o_last  (w_exit_last),
        .o_valid (w_exit_valid)
    );

    // Running sum for the beat at pipe exit, its shifted form and the reduced result.
    always_comb begin
        w_p_ext = acc_WIDTH'(w_exit_p);
        if (w_exit_first) begin
            w_sum = w_p_ext;
        end else begin
            w_sum = r_acc + w_p_ext;
        end
        // Arithmetic shift of a signed value rounds toward minus infinity.
        w_shift = w_sum >>> FRAC_SHIFT;
`ifdef CNN_MAC_SAT_EN
        w_dout = dout_WIDTH'(sat_clip(64'(w_shift), dout_WIDTH));
        w_clip = sat_out_of_range(64'(w_shift), dout_WIDTH);
`else
        w_dout = dout_WIDTH'(w_shift);
        w_clip = 1'b0;
`endif
    end

    // Accumulator and output register; everything holds while stalled.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc       <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else if (w_in_ready) begin
            if (w_exit_valid) begin
                r_acc <= w_sum;
            end
            if (w_exit_valid && w_exit_last) begin
                r_dout      <= w_dout;
                r_sat       <= w_clip;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign dout      = r_dout;
    assign out_valid = r_out_valid;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_cnn_mul_acc_pipe.sv
// -----------------------------------------------------------------------------
// tb_cnn_mul_acc_pipe
// Two instances share one input stream: dut (FRAC_SHIFT=0) and dut_fs
// (FRAC_SHIFT=2). A window-level model computes each window's sum when its
// closing beat is accepted and queues the expected results for both shifts.
// -----------------------------------------------------------------------------
module tb_cnn_mul_acc_pipe;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic signed [7:0]  din0;
    logic signed [13:0] din1;
    logic               in_first, in_last, in_valid, out_ready;
    logic               in_ready, in_ready_fs;
    logic signed [15:0] dout, dout_fs;
    logic               out_valid, out_valid_fs, sat_flag, sat_flag_fs;

    always #5 ap_clk = ~ap_clk;

    cnn_mul_acc_pipe dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(din0), .din1(din1),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag)
    );

    cnn_mul_acc_pipe #(.FRAC_SHIFT(2)) dut_fs (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(din0), .din1(din1),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready_fs),
        .dout(dout_fs), .out_valid(out_valid_fs), .out_ready(out_ready), .sat_flag(sat_flag_fs)
    );

    typedef struct {
        logic signed [15:0] d0;
        logic               s0;
        logic signed [15:0] d2;
        logic               s2;
    } exp_t;

    int                 n_vec = 0;
    int                 n_err = 0;
    exp_t               exp_q[$];
    logic signed [31:0] m_acc;
    bit                 rand_ready = 1'b0;
    bit                 accepted;
    logic signed [15:0] hold;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Reduce a shifted window sum to the 16-bit result.
    function automatic void reduce(input longint v, output logic signed [15:0] d, output logic s);
`ifdef CNN_MAC_SAT_EN
        if (v > 64'sd32767) begin
            d = 16'sh7fff; s = 1'b1;
        end else if (v < -64'sd32768) begin
            d = 16'sh8000; s = 1'b1;
        end else begin
            d = 16'(v); s = 1'b0;
        end
`else
        d = 16'(v);
        s = 1'b0;
`endif
    endfunction

    task automatic model_accept();
        longint p;
        exp_t   e;
        p = longint'(din0) * longint'(din1);
        if (in_first) m_acc = 32'(p);
        else          m_acc = m_acc + 32'(p);
        if (in_last) begin
            reduce(longint'(m_acc), e.d0, e.s0);
            reduce(longint'(m_acc) >>> 2, e.d2, e.s2);
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample at the falling edge, then return 1 ns after the rising edge.
    task automatic tick();
        exp_t e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(negedge ap_clk);
        accepted = in_valid && in_ready && ap_rst_n;
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        chk("in_ready_fs", in_ready_fs, in_ready);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("dout", dout, e.d0);
                chk("sat_flag", sat_flag, e.s0);
                chk("out_valid_fs", out_valid_fs, 1'b1);
                chk("dout_fs", dout_fs, e.d2);
                chk("sat_flag_fs", sat_flag_fs, e.s2);
            end
        end
        if (accepted) model_accept();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_beat(input int a, input int b, input bit f, input bit l);
        din0 = 8'(a); din1 = 14'(b); in_first = f; in_last = l; in_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) chk("accept_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 64; k++) begin
            if (out_valid) break;
            tick();
        end
        chk("out_timeout", out_valid, 1'b1);
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        ap_rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dout", dout, 16'sd0);
        chk("rst_sat", sat_flag, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid_fs", out_valid_fs, 1'b0);
        chk("rst_dout_fs", dout_fs, 16'sd0);
        exp_q.delete();
        m_acc = 32'sd0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        ap_rst_n = 1'b0; din0 = 8'sd0; din1 = 14'sd0;
        in_first = 1'b0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        m_acc = 32'sd0;
        #12;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_dout", dout, 16'sd0);
        chk("reset_sat", sat_flag, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Three-beat window summing 130, result four cycles after the last beat.
        send_beat(3, 100, 1'b1, 1'b0);
        send_beat(-2, 50, 1'b0, 1'b0);
        send_beat(10, -7, 1'b0, 1'b1);
        tick();
        tick();
        chk("latency_early", out_valid, 1'b0);
        tick();
        chk("latency_on", out_valid, 1'b1);
        chk("win130_dout", dout, 16'sd130);
        chk("win130_sat", sat_flag, 1'b0);
        chk("win130_fs", dout_fs, 16'sd32);

        // Window summing -130: floor shift gives -33.
        send_beat(-3, 100, 1'b1, 1'b0);
        send_beat(2, 50, 1'b0, 1'b0);
        send_beat(-10, -7, 1'b0, 1'b1);
        wait_out();
        chk("winm130_dout", dout, -16'sd130);
        chk("winm130_fs", dout_fs, -16'sd33);

        // One-beat window exceeding the result range.
        send_beat(-128, 8191, 1'b1, 1'b1);
        wait_out();
`ifdef CNN_MAC_SAT_EN
        chk("big_dout", dout, -16'sd32768);
        chk("big_sat", sat_flag, 1'b1);
`else
        chk("big_dout", dout, 16'sd128);
        chk("big_sat", sat_flag, 1'b0);
`endif
        drain();

        // Back-to-back one-beat windows: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 16383)) - 8192, 1'b1, 1'b1);
            if (i >= 3) chk("stream_valid", out_valid, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stream_tail", out_valid, 1'b1);
        end
        tick();
        chk("stream_end", out_valid, 1'b0);
        drain();

        // Consumer stall while input keeps streaming.
        for (int i = 0; i < 6; i++)
            send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 16383)) - 8192, 1'b1, 1'b1);
        din0 = 8'sd11; din1 = 14'sd13; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        hold = dout;
        for (int i = 0; i < 4; i++) begin
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            tick();
            chk("stall_dout", dout, hold);
        end
        out_ready = 1'b1;
        send_beat(11, 13, 1'b1, 1'b1);
        send_beat(2, 3, 1'b1, 1'b0);
        send_beat(4, 5, 1'b0, 1'b1);
        drain();

        // Reset in the middle of a window, with a result sitting in the output.
        send_beat(1, 1, 1'b1, 1'b1);
        send_beat(7, 9, 1'b1, 1'b0);
        send_beat(4, 4, 1'b0, 1'b0);
        tick();
        chk("pre_reset_valid", out_valid, 1'b1);
        pulse_reset();
        send_beat(5, 5, 1'b1, 1'b1);
        wait_out();
        chk("post_reset_dout", dout, 16'sd25);
        drain();
        send_beat(7, 9, 1'b1, 1'b0);
        pulse_reset();
        send_beat(3, 4, 1'b0, 1'b1);
        wait_out();
        chk("post_reset_nofirst", dout, 16'sd12);
        drain();

        // Random windows with random consumer back-pressure.
        rand_ready = 1'b1;
        for (int w = 0; w < 40; w++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 16383)) - 8192,
                          j == 0, j == len - 1);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
